idli_sqi_mem_m: RTL and testbench

- Behavioural SQI SRAM slave that sits directly downstream of the core's SQI port. The bench instantiates one per lane (hi, lo) and connects it to the core's sck/cs/sio signals.
- Decodes quad-mode READ and WRITE transactions against a byte-addressed array. Returns read data on sio so the core can fetch instructions and data without an external script model.
- Everything is sampled in the gck domain. sck is treated as a data input and edge-detected, not used as a clock.

---
 rtl/idli_sqi_mem_m.sv | 165 ++++++++++++++++
 tb/tb_idli_sqi_mem_m.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/idli_sqi_mem_m.sv
// Behavioural quad-SPI SRAM slave: decodes READ (0x03) / WRITE (0x02) against a byte array.
// sck is an ordinary input sampled on gck; rises capture sio, falls launch the next read nibble.
module idli_sqi_mem_m #(
    parameter int ADDR_W    = 16,
    parameter int DUMMY_NIB = 2
) (
    input  logic       i_mem_gck,
    input  logic       i_mem_rst,
    input  logic       i_mem_sck,
    input  logic       i_mem_cs,
    input  logic [3:0] i_mem_sio,
    output logic [3:0] o_mem_sio,
    output logic       o_mem_sio_oe,
    output logic       o_mem_err
);

    localparam logic [7:0] ADDR_LAST  = 8'(ADDR_W / 4 - 1);
    localparam logic [7:0] DUMMY_LAST = (DUMMY_NIB > 0) ? 8'(DUMMY_NIB - 1) : 8'd0;

    typedef enum logic [2:0] {
        ST_IDLE, ST_INSTR, ST_ADDR, ST_DUMMY, ST_READ, ST_WRITE, ST_IGNORE
    } state_t;

    logic [7:0] mem [2**ADDR_W];

    state_t            state_q, state_d;
    logic              sck_q;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        nib_cnt_q, nib_cnt_d;
    logic              is_rd_q, is_rd_d;
    logic              phase_q, phase_d;
    logic [3:0]        hi_q, hi_d;
    logic [3:0]        sio_q, sio_d;
    logic              oe_q, oe_d;
    logic              err_q, err_d;
    logic              wr_en;
    logic              rise, fall;
    logic [7:0]        rd_byte;

    assign rise    = i_mem_sck & ~sck_q;
    assign fall    = ~i_mem_sck & sck_q;
    assign rd_byte = mem[addr_q];

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        nib_cnt_d = nib_cnt_q;
        is_rd_d   = is_rd_q;
        phase_d   = phase_q;
        hi_d      = hi_q;
        sio_d     = sio_q;
        oe_d      = oe_q;
        err_d     = err_q;
        wr_en     = 1'b0;
        if (i_mem_cs) begin
            // Deselect drops everything, including a half-received write byte.
            state_d   = ST_IDLE;
            oe_d      = 1'b0;
            sio_d     = 4'h0;
            nib_cnt_d = 8'd0;
            phase_d   = 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    state_d   = ST_INSTR;
                    nib_cnt_d = 8'd0;
                end
                ST_INSTR: if (rise) begin
                    // Instruction and address share the addr shift register.
                    addr_d = ADDR_W'({addr_q, i_mem_sio});
                    if (nib_cnt_q == 8'd1) begin
                        nib_cnt_d = 8'd0;
                        case ({addr_q[3:0], i_mem_sio})
                            8'h03: begin state_d = ST_ADDR; is_rd_d = 1'b1; end
                            8'h02: begin state_d = ST_ADDR; is_rd_d = 1'b0; end
                            default: begin state_d = ST_IGNORE; err_d = 1'b1; end
                        endcase
                    end else begin
                        nib_cnt_d = nib_cnt_q + 8'd1;
                    end
                end
                ST_ADDR: if (rise) begin
                    addr_d = ADDR_W'({addr_q, i_mem_sio});
                    if (nib_cnt_q == ADDR_LAST) begin
                        nib_cnt_d = 8'd0;
                        phase_d   = 1'b0;
                        if (!is_rd_q)           state_d = ST_WRITE;
                        else if (DUMMY_NIB == 0) state_d = ST_READ;
                        else                    state_d = ST_DUMMY;
                    end else begin
                        nib_cnt_d = nib_cnt_q + 8'd1;
                    end
                end
                ST_DUMMY: if (rise) begin
                    if (nib_cnt_q == DUMMY_LAST) begin
                        nib_cnt_d = 8'd0;
                        phase_d   = 1'b0;
                        state_d   = ST_READ;
                    end else begin
                        nib_cnt_d = nib_cnt_q + 8'd1;
                    end
                end
                ST_READ: if (fall) begin
                    oe_d = 1'b1;
                    if (!phase_q) begin
                        sio_d   = rd_byte[7:4];
                        phase_d = 1'b1;
                    end else begin
                        sio_d   = rd_byte[3:0];
                        phase_d = 1'b0;
                        addr_d  = addr_q + 1'b1;
                    end
                end
                ST_WRITE: if (rise) begin
                    if (!phase_q) begin
                        hi_d    = i_mem_sio;
                        phase_d = 1'b1;
                    end else begin
                        wr_en   = 1'b1;
                        phase_d = 1'b0;
                        addr_d  = addr_q + 1'b1;
                    end
                end
                ST_IGNORE: ;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_mem_gck) begin
        if (i_mem_rst) begin
            state_q   <= ST_IDLE;
            sck_q     <= 1'b0;
            addr_q    <= '0;
            nib_cnt_q <= 8'd0;
            is_rd_q   <= 1'b0;
            phase_q   <= 1'b0;
            hi_q      <= 4'h0;
            sio_q     <= 4'h0;
            oe_q      <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            sck_q     <= i_mem_sck;
            addr_q    <= addr_d;
            nib_cnt_q <= nib_cnt_d;
            is_rd_q   <= is_rd_d;
            phase_q   <= phase_d;
            hi_q      <= hi_d;
            sio_q     <= sio_d;
            oe_q      <= oe_d;
            err_q     <= err_d;
        end
    end

    // Storage has no reset so preloaded contents survive i_mem_rst.
    always_ff @(posedge i_mem_gck) begin
        if (wr_en && !i_mem_rst) mem[addr_q] <= {hi_q, i_mem_sio};
    end

    assign o_mem_sio    = sio_q;
    assign o_mem_sio_oe = oe_q;
    assign o_mem_err    = err_q;

endmodule

// File: tb/tb_idli_sqi_mem_m.sv
// Directed bench for idli_sqi_mem_m: write, read, wrap, abort, bad instruction, reset mid-read.
module tb_idli_sqi_mem_m;

    logic       gck = 1'b0;
    logic       rst = 1'b1;
    logic       sck = 1'b0;
    logic       cs  = 1'b1;
    logic [3:0] sio_in = 4'h0;
    logic [3:0] sio_out;
    logic       oe;
    logic       err;

    int n_checks = 0;
    int n_fail   = 0;

    logic [3:0] rs;
    logic       roe;
    logic       oe_seen;

    idli_sqi_mem_m #(.ADDR_W(16), .DUMMY_NIB(2)) dut (
        .i_mem_gck   (gck),
        .i_mem_rst   (rst),
        .i_mem_sck   (sck),
        .i_mem_cs    (cs),
        .i_mem_sio   (sio_in),
        .o_mem_sio   (sio_out),
        .o_mem_sio_oe(oe),
        .o_mem_err   (err)
    );

    always #5 gck = ~gck;

    // One full sck period (2 gck high, 2 gck low); samples outputs after the fall is registered.
    task automatic sck_cycle(input logic [3:0] d);
        @(negedge gck); sio_in = d; sck = 1'b1;
        repeat (2) @(negedge gck);
        sck = 1'b0;
        repeat (2) @(negedge gck);
        rs  = sio_out;
        roe = oe;
        oe_seen = oe_seen | oe;
    endtask

    task automatic cs_low();
        @(negedge gck); cs = 1'b0; sck = 1'b0;
        repeat (2) @(negedge gck);
        oe_seen = 1'b0;
    endtask

    task automatic cs_high();
        @(negedge gck); cs = 1'b1; sck = 1'b0;
        repeat (2) @(negedge gck);
    endtask

    task automatic send_hdr(input logic [7:0] ins, input logic [15:0] a);
        sck_cycle(ins[7:4]); sck_cycle(ins[3:0]);
        sck_cycle(a[15:12]); sck_cycle(a[11:8]); sck_cycle(a[7:4]); sck_cycle(a[3:0]);
    endtask

    task automatic test_reset();
        rst = 1'b1; cs = 1'b1;
        repeat (3) @(negedge gck);
        if (oe !== 1'b0) begin $display("FAIL rst_oe got=%b exp=0", oe); n_fail++; end
        n_checks++;
        if (sio_out !== 4'h0) begin $display("FAIL rst_sio got=%h exp=0", sio_out); n_fail++; end
        n_checks++;
        if (err !== 1'b0) begin $display("FAIL rst_err got=%b exp=0", err); n_fail++; end
        n_checks++;
        rst = 1'b0;
        repeat (2) @(negedge gck);
    endtask

    task automatic test_write();
        dut.mem[16'h1234] = 8'h00;
        dut.mem[16'h1235] = 8'h00;
        cs_low();
        send_hdr(8'h02, 16'h1234);
        sck_cycle(4'hA); sck_cycle(4'hB); sck_cycle(4'hC); sck_cycle(4'hD);
        cs_high();
        if (oe_seen !== 1'b0) begin $display("FAIL wr_oe got=%b exp=0", oe_seen); n_fail++; end
        n_checks++;
        if (dut.mem[16'h1234] !== 8'hAB) begin
            $display("FAIL wr_byte0 got=%h exp=ab", dut.mem[16'h1234]); n_fail++; end
        n_checks++;
        if (dut.mem[16'h1235] !== 8'hCD) begin
            $display("FAIL wr_byte1 got=%h exp=cd", dut.mem[16'h1235]); n_fail++; end
        n_checks++;
    endtask

    task automatic test_read();
        logic [3:0] exp_n [4];
        exp_n[0] = 4'hA; exp_n[1] = 4'hB; exp_n[2] = 4'hC; exp_n[3] = 4'hD;
        cs_low();
        send_hdr(8'h03, 16'h1234);
        sck_cycle(4'h0);
        if (roe !== 1'b0) begin $display("FAIL rd_dummy1_oe got=%b exp=0", roe); n_fail++; end
        n_checks++;
        for (int i = 0; i < 4; i++) begin
            sck_cycle(4'h0);
            if (roe !== 1'b1 || rs !== exp_n[i]) begin
                $display("FAIL rd_nib%0d got=%b/%h exp=1/%h", i, roe, rs, exp_n[i]); n_fail++; end
            n_checks++;
        end
        @(negedge gck); cs = 1'b1; sck = 1'b0;
        @(negedge gck);
        if (oe !== 1'b0 || sio_out !== 4'h0) begin
            $display("FAIL rd_cs_drop got=%b/%h exp=0/0", oe, sio_out); n_fail++; end
        n_checks++;
        repeat (2) @(negedge gck);
        if (dut.mem[16'h1234] !== 8'hAB || dut.mem[16'h1235] !== 8'hCD) begin
            $display("FAIL rd_mem_kept got=%h%h exp=abcd", dut.mem[16'h1234], dut.mem[16'h1235]);
            n_fail++; end
        n_checks++;
    endtask

    task automatic test_wrap();
        logic [3:0] exp_n [4];
        exp_n[0] = 4'h5; exp_n[1] = 4'hA; exp_n[2] = 4'hC; exp_n[3] = 4'h3;
        dut.mem[16'hFFFF] = 8'h5A;
        dut.mem[16'h0000] = 8'hC3;
        cs_low();
        send_hdr(8'h03, 16'hFFFF);
        sck_cycle(4'h0);
        for (int i = 0; i < 4; i++) begin
            sck_cycle(4'h0);
            if (rs !== exp_n[i]) begin
                $display("FAIL wrap_nib%0d got=%h exp=%h", i, rs, exp_n[i]); n_fail++; end
            n_checks++;
        end
        cs_high();
    endtask

    task automatic test_abort();
        dut.mem[16'h0010] = 8'h96;
        cs_low();
        send_hdr(8'h02, 16'h0010);
        sck_cycle(4'h7);
        cs_high();
        if (dut.mem[16'h0010] !== 8'h96) begin
            $display("FAIL abort_mem got=%h exp=96", dut.mem[16'h0010]); n_fail++; end
        n_checks++;
        cs_low();
        send_hdr(8'h03, 16'h0010);
        sck_cycle(4'h0);
        sck_cycle(4'h0);
        if (rs !== 4'h9) begin $display("FAIL abort_rd_hi got=%h exp=9", rs); n_fail++; end
        n_checks++;
        sck_cycle(4'h0);
        if (rs !== 4'h6) begin $display("FAIL abort_rd_lo got=%h exp=6", rs); n_fail++; end
        n_checks++;
        cs_high();
    endtask

    task automatic test_bad_instr();
        cs_low();
        sck_cycle(4'h0); sck_cycle(4'hF);
        if (err !== 1'b1) begin $display("FAIL bad_err got=%b exp=1", err); n_fail++; end
        n_checks++;
        for (int i = 0; i < 6; i++) sck_cycle(4'(i + 1));
        if (oe_seen !== 1'b0) begin $display("FAIL bad_oe got=%b exp=0", oe_seen); n_fail++; end
        n_checks++;
        cs_high();
        cs_low();
        send_hdr(8'h03, 16'h1234);
        sck_cycle(4'h0);
        sck_cycle(4'h0);
        if (rs !== 4'hA || roe !== 1'b1) begin
            $display("FAIL bad_then_rd got=%b/%h exp=1/a", roe, rs); n_fail++; end
        n_checks++;
        cs_high();
        if (err !== 1'b1) begin $display("FAIL bad_err_sticky got=%b exp=1", err); n_fail++; end
        n_checks++;
        @(negedge gck); rst = 1'b1;
        @(negedge gck); rst = 1'b0;
        if (err !== 1'b0) begin $display("FAIL bad_err_clr got=%b exp=0", err); n_fail++; end
        n_checks++;
    endtask

    task automatic test_reset_mid_read();
        cs_low();
        send_hdr(8'h03, 16'h1234);
        sck_cycle(4'h0);
        sck_cycle(4'h0);
        if (rs !== 4'hA) begin $display("FAIL rmr_pre got=%h exp=a", rs); n_fail++; end
        n_checks++;
        @(negedge gck); rst = 1'b1;
        @(negedge gck);
        if (oe !== 1'b0 || sio_out !== 4'h0) begin
            $display("FAIL rmr_out got=%b/%h exp=0/0", oe, sio_out); n_fail++; end
        n_checks++;
        rst = 1'b0;
        cs_high();
        if (dut.mem[16'h1234] !== 8'hAB) begin
            $display("FAIL rmr_mem got=%h exp=ab", dut.mem[16'h1234]); n_fail++; end
        n_checks++;
    endtask

    initial begin
        oe_seen = 1'b0;
        rs = 4'h0;
        roe = 1'b0;
        test_reset();
        test_write();
        test_read();
        test_wrap();
        test_abort();
        test_bad_instr();
        test_reset_mid_read();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
